updi_rx_controller: RTL

Transaction-level controller for `updi_input_handler`. It accepts receive commands from the UPDI instruction engine: either "expect ACK" or "forward N bytes". It sequences the handler's `wait_ack`/`start` controls and supervises completion with a programmable timeout. On timeout or abort it recovers the handler through its synchronous reset. Each command ends with exactly one status response.

---
 rtl/updi_pkg.sv | 13 +
 rtl/updi_rx_controller.sv | 99 +++++++++
 2 files changed

// File: rtl/updi_pkg.sv
// updi_pkg: shared state and status encodings for the UPDI receive path
package updi_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_RECOVER, ST_RESPOND
  } updi_rx_ctrl_state;
  typedef enum logic [2:0] {
    RX_OK      = 3'd0,
    RX_NACK    = 3'd1,
    RX_TIMEOUT = 3'd2,
    RX_ABORTED = 3'd3,
    RX_BAD_LEN = 3'd4
  } updi_rx_status;
endpackage

// File: rtl/updi_rx_controller.sv
// updi_rx_controller: sequences updi_input_handler per command and returns one status each
module updi_rx_controller
  import updi_pkg::*;
#(
  parameter int BITS_N    = 6,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_ack,
  input  logic [BITS_N-1:0]    cmd_n_bytes,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 abort,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [2:0]           resp_status,
  output logic                 hdlr_rst,
  output logic                 hdlr_wait_ack,
  output logic                 hdlr_start,
  output logic [BITS_N-1:0]    hdlr_n_bytes,
  input  logic                 hdlr_ready,
  input  logic                 hdlr_done,
  input  logic                 hdlr_ack_received,
  input  logic                 hdlr_ack_error
);
  updi_rx_ctrl_state state_q, state_d;
  updi_rx_status     status_q, status_d;
  logic                 ack_q, ack_d;
  logic [BITS_N-1:0]    n_q, n_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_W:0]   cnt_inc;
  logic                 busy, expired, complete;
  assign busy     = state_q == ST_ISSUE || state_q == ST_WAIT;
  assign cnt_inc  = {1'b0, cnt_q} + (TIMEOUT_W+1)'(1);
  assign expired  = timeout_cycles != '0 && cnt_inc >= {1'b0, timeout_cycles};
  // an ACK-mode handler dropping back to ready without an ACK counts as completion (NACK)
  assign complete = state_q == ST_WAIT &&
                    (ack_q ? (hdlr_ack_received || hdlr_ack_error || hdlr_ready) : hdlr_done);
  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    ack_d         = ack_q;
    n_d           = n_q;
    cnt_d         = busy ? cnt_inc[TIMEOUT_W-1:0] : cnt_q;
    hdlr_start    = 1'b0;
    hdlr_wait_ack = 1'b0;
    unique case (state_q)
      ST_IDLE: if (cmd_valid) begin
        ack_d    = cmd_ack;
        n_d      = cmd_n_bytes;
        cnt_d    = '0;
        status_d = RX_BAD_LEN;
        state_d  = (!cmd_ack && cmd_n_bytes == '0) ? ST_RESPOND : ST_ISSUE;
      end
      ST_ISSUE, ST_WAIT: begin
        if (complete) begin
          state_d  = ST_RESPOND;
          status_d = (!ack_q || hdlr_ack_received) ? RX_OK : RX_NACK;
        end else if (abort) begin
          state_d  = ST_RECOVER;
          status_d = RX_ABORTED;
        end else if (expired) begin
          state_d  = ST_RECOVER;
          status_d = RX_TIMEOUT;
        end else if (state_q == ST_ISSUE && hdlr_ready) begin
          state_d       = ST_WAIT;
          hdlr_start    = !ack_q;
          hdlr_wait_ack = ack_q;
        end
      end
      ST_RECOVER: state_d = ST_RESPOND;
      ST_RESPOND: state_d = resp_ready ? ST_IDLE : ST_RESPOND;
      default:    state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      status_q <= RX_OK;
      ack_q    <= 1'b0;
      n_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      ack_q    <= ack_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
    end
  end
  // reset also holds the handler in reset and blocks new commands
  assign cmd_ready    = rst_n && state_q == ST_IDLE;
  assign resp_valid   = state_q == ST_RESPOND;
  assign resp_status  = resp_valid ? status_q : RX_OK;
  assign hdlr_rst     = !rst_n || state_q == ST_RECOVER;
  assign hdlr_n_bytes = n_q;
endmodule
